csi2_packet_builder: RTL
========================

// Module: csi2_packet_builder
// PURPOSE
//  Builds CSI-2 packets for the D-PHY HS transmitter, one byte per byteclk.
//  - Short packets: 4-byte header = DI, WC lsb, WC msb, ECC.
//  - Long packets: header, then WC payload bytes, then CRC-16 (lsb first).
//  Sits between the line/frame sequencer (request + payload) and the D-PHY lane FSM.
// PARAMETERS
//  MIN_GAP  4  idle byteclk cycles forced after pkt_last handshake (PHY HS-trail/LP exit)
// PORTS
//  byteclk      in   1   clock; all logic on rising edge
//  areset       in   1   synchronous, active-high reset
//  req_valid    in   1   packet request
//  req_ready    out  1   high only in IDLE
//  req_vc       in   2   virtual channel
//  req_dt       in   6   data type; dt<0x10 = short packet, else long
//  req_wc       in   16  long: payload byte count; short: 16-bit data field
//  pl_data      in   8   payload byte
//  pl_valid     in   1   payload byte available
//  pl_ready     out  1   payload byte taken this cycle
//  pkt_data     out  8   byte to PHY
//  pkt_valid    out  1   byte valid; high continuously from header byte 0 to pkt_last
//  pkt_last     out  1   marks final byte (ECC for short, CRC msb for long)
//  pkt_ready    in   1   PHY accepts byte
//  err_underrun out  1   sticky; cleared only by areset
// BEHAVIOUR
//  Reset: IDLE; req_ready=1, pl_ready=0, pkt_valid=0, pkt_last=0, pkt_data=0, err_underrun=0.
//  Latency: request accepted at edge N -> header byte 0 on pkt_valid after edge N+1.
//  Request latching: DI={vc,dt}, wc, long flag latched on accept; req_* ignored otherwise.
//  ECC over D[23:0]={WC msb,WC lsb,DI}, D0=DI bit0; ECC[7:6]=0; Pn = XOR of listed D bits:
//   P0: 0,1,2,4,5,7,10,11,13,16,20,21,22,23
//   P1: 0,1,3,4,6,8,10,12,14,17,20,21,22,23
//   P2: 0,2,3,5,6,9,11,12,15,18,20,21,22
//   P3: 1,2,3,7,8,9,13,14,15,19,20,21,23
//   P4: 4,5,6,7,8,9,16,17,18,19,20,22,23
//   P5: 10,11,12,13,14,15,16,17,18,19,21,22,23
//  CRC-16: poly x^16+x^12+x^5+1 (reflected 0x8408), init 0xFFFF, bytes fed lsb first.
//   Covers payload bytes only, no final XOR.
//  FSM states:
//   IDLE: req_valid -> HDR, byte index 0.
//   HDR: 4 bytes, index advances per pkt_valid&pkt_ready. After byte 3:
//     short -> GAP; long with wc=0 -> CRC; else PAYLOAD.
//   PAYLOAD: pl_ready = pkt_ready | ~pkt_valid.
//     Each handshake loads pl_data to output, updates CRC, decrements remaining count.
//     Underrun (output slot free, pl_valid=0): emit 0x00, counted and CRC'd as payload.
//       Sets err_underrun; pl_ready stays high. pkt_valid never drops mid-packet.
//     Remaining 0 -> CRC.
//   CRC: emits crc[7:0], then crc[15:8] with pkt_last=1 -> GAP. wc=0 emits FF FF.
//   GAP: pkt_valid=0, MIN_GAP cycles -> IDLE. MIN_GAP=0 -> IDLE next cycle.
//  Output register: pkt_data/pkt_last held stable while pkt_valid & ~pkt_ready.
//  wc counter: 16-bit; wc=0xFFFF fully supported, no wrap.
//  areset mid-packet: next edge IDLE, pkt_valid=0, partial packet dropped, CRC reinit.
// TESTING
//  1. Short vc=0,dt=0x01,wc=0x0005 -> bytes 01 05 00 3E; pkt_last on 3E; req_ready low >=4+MIN_GAP cycles.
//  2. Long dt=0x12, wc=24, payload FF 00 00 02 B9 DC F3 72 BB D4 B8 5A C8 75 C2 7C 81 F8 05 DF FF 00 00 01
//     -> header, 24 bytes verbatim, then F0 00 (CRC 0x00F0).
//  3. Long wc=0 -> 4 header bytes then FF FF; pl_ready never asserted.
//  4. pkt_ready toggled randomly during test 2 -> identical byte sequence, no drop/duplicate, data stable while stalled.
//  5. pl_valid low for 3 cycles mid-payload -> three 0x00 bytes inserted, err_underrun=1, total payload still wc.
//  6. areset during PAYLOAD -> pkt_valid=0 next cycle; next packet bytes and CRC correct.

Source files
------------

// File: rtl/csi2_packet_builder.sv
// ----------------------------------------------------------------------------
// csi2_packet_builder
//   Serialises MIPI CSI-2 packets for a D-PHY HS transmitter, one byte per
//   byteclk. Short packets are a 4-byte header (DI, WC lsb, WC msb, ECC).
//   Long packets are the header, WC payload bytes taken from the sequencer,
//   then a CRC-16 over the payload, sent lsb first. After the final byte is
//   accepted, MIN_GAP idle cycles are forced so the PHY can run HS-trail and
//   LP exit.
//
// Ports
//   byteclk      in   clock, all logic on rising edge
//   areset       in   synchronous active-high reset
//   req_valid    in   packet request
//   req_ready    out  high only while idle
//   req_vc       in   [1:0]  virtual channel
//   req_dt       in   [5:0]  data type (< 0x10 short, else long)
//   req_wc       in   [15:0] long: payload byte count; short: data field
//   pl_data      in   [7:0]  payload byte
//   pl_valid     in   payload byte available
//   pl_ready     out  payload byte taken this cycle
//   pkt_data     out  [7:0]  byte to PHY
//   pkt_valid    out  byte valid, gapless from header byte 0 to pkt_last
//   pkt_last     out  final byte of the packet
//   pkt_ready    in   PHY accepts byte
//   err_underrun out  sticky payload-underrun flag, cleared by areset
// ----------------------------------------------------------------------------
module csi2_packet_builder #(
  parameter int MIN_GAP = 4
) (
  input  logic        byteclk,
  input  logic        areset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_vc,
  input  logic [5:0]  req_dt,
  input  logic [15:0] req_wc,
  input  logic [7:0]  pl_data,
  input  logic        pl_valid,
  output logic        pl_ready,
  output logic [7:0]  pkt_data,
  output logic        pkt_valid,
  output logic        pkt_last,
  input  logic        pkt_ready,
  output logic        err_underrun
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HDR     = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_CRC     = 3'd3;
  localparam logic [2:0] S_GAP     = 3'd4;

  // Last value of the gap counter before returning to idle; a zero gap still
  // spends the single GAP cycle.
  localparam logic [15:0] GAP_LAST = (MIN_GAP > 1) ? 16'(MIN_GAP - 1) : 16'd0;

  // CSI-2 header ECC: 6 parity bits over {WC msb, WC lsb, DI}, bits 7:6 zero.
  function automatic logic [7:0] ecc24(input logic [23:0] d);
    logic [7:0] p;
    p    = 8'h00;
    p[0] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7] ^ d[10] ^ d[11] ^ d[13] ^
           d[16] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
    p[1] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10] ^ d[12] ^ d[14] ^
           d[17] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
    p[2] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[11] ^ d[12] ^ d[15] ^
           d[18] ^ d[20] ^ d[21] ^ d[22];
    p[3] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[13] ^ d[14] ^ d[15] ^
           d[19] ^ d[20] ^ d[21] ^ d[23];
    p[4] = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[16] ^ d[17] ^ d[18] ^
           d[19] ^ d[20] ^ d[22] ^ d[23];
    p[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16] ^ d[17] ^
           d[18] ^ d[19] ^ d[21] ^ d[22] ^ d[23];
    return p;
  endfunction

  // Reflected CRC-16 (poly 0x8408), one byte, lsb first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] b);
    logic [15:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ b[i]) begin
        c = (c >> 1) ^ 16'h8408;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

  logic [2:0]  state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  di_q, di_d;
  logic [15:0] wc_q, wc_d;
  logic        long_q, long_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] crc_q, crc_d;
  logic [15:0] gap_q, gap_d;
  logic [7:0]  pkt_data_q, pkt_data_d;
  logic        pkt_valid_q, pkt_valid_d;
  logic        pkt_last_q, pkt_last_d;
  logic        err_q, err_d;

  logic        slot_free;
  logic [7:0]  ecc_byte;
  logic [7:0]  hdr_byte;
  logic [7:0]  pay_byte;

  // The output register can take a new byte when empty or being drained.
  assign slot_free = ~pkt_valid_q | pkt_ready;
  assign ecc_byte  = ecc24({wc_q[15:8], wc_q[7:0], di_q});

  assign req_ready    = (state_q == S_IDLE);
  assign pl_ready     = (state_q == S_PAYLOAD) & slot_free;
  assign pkt_data     = pkt_data_q;
  assign pkt_valid    = pkt_valid_q;
  assign pkt_last     = pkt_last_q;
  assign err_underrun = err_q;

  // Header byte selected by the header index.
  always_comb begin
    case (idx_q[1:0])
      2'd0:    hdr_byte = di_q;
      2'd1:    hdr_byte = wc_q[7:0];
      2'd2:    hdr_byte = wc_q[15:8];
      2'd3:    hdr_byte = ecc_byte;
      default: hdr_byte = 8'h00;
    endcase
  end

  // Payload byte: a missing sequencer byte is replaced by a filler zero.
  always_comb begin
    if (pl_valid) begin
      pay_byte = pl_data;
    end else begin
      pay_byte = 8'h00;
    end
  end

  // Packet sequencing and output register next-state.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    di_d        = di_q;
    wc_d        = wc_q;
    long_d      = long_q;
    rem_d       = rem_q;
    crc_d       = crc_q;
    gap_d       = gap_q;
    pkt_data_d  = pkt_data_q;
    pkt_valid_d = pkt_valid_q;
    pkt_last_d  = pkt_last_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          di_d    = {req_vc, req_dt};
          wc_d    = req_wc;
          rem_d   = req_wc;
          long_d  = (req_dt >= 6'h10);
          crc_d   = 16'hFFFF;
          idx_d   = 3'd0;
          state_d = S_HDR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HDR: begin
        if (!slot_free) begin
          state_d = S_HDR;
        end else if (idx_q == 3'd4) begin
          // Short packet: ECC byte (pkt_last) has just been accepted.
          pkt_valid_d = 1'b0;
          pkt_last_d  = 1'b0;
          gap_d       = 16'd0;
          state_d     = S_GAP;
        end else begin
          pkt_valid_d = 1'b1;
          pkt_data_d  = hdr_byte;
          pkt_last_d  = 1'b0;
          idx_d       = idx_q + 3'd1;
          if (idx_q != 3'd3) begin
            state_d = S_HDR;
          end else if (!long_q) begin
            pkt_last_d = 1'b1;
            state_d    = S_HDR;
          end else if (wc_q == 16'd0) begin
            idx_d   = 3'd0;
            state_d = S_CRC;
          end else begin
            state_d = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (slot_free) begin
          pkt_valid_d = 1'b1;
          pkt_last_d  = 1'b0;
          pkt_data_d  = pay_byte;
          crc_d       = crc16_byte(crc_q, pay_byte);
          rem_d       = rem_q - 16'd1;
          if (!pl_valid) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          if (rem_q == 16'd1) begin
            idx_d   = 3'd0;
            state_d = S_CRC;
          end else begin
            state_d = S_PAYLOAD;
          end
        end else begin
          state_d = S_PAYLOAD;
        end
      end
      S_CRC: begin
        if (slot_free) begin
          case (idx_q)
            3'd0: begin
              pkt_valid_d = 1'b1;
              pkt_data_d  = crc_q[7:0];
              pkt_last_d  = 1'b0;
              idx_d       = 3'd1;
            end
            3'd1: begin
              pkt_valid_d = 1'b1;
              pkt_data_d  = crc_q[15:8];
              pkt_last_d  = 1'b1;
              idx_d       = 3'd2;
            end
            default: begin
              // CRC msb accepted: packet complete.
              pkt_valid_d = 1'b0;
              pkt_last_d  = 1'b0;
              gap_d       = 16'd0;
              state_d     = S_GAP;
            end
          endcase
        end else begin
          state_d = S_CRC;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        pkt_valid_d = 1'b0;
        pkt_last_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge byteclk) begin
    if (areset) begin
      state_q     <= S_IDLE;
      idx_q       <= 3'd0;
      di_q        <= 8'h00;
      wc_q        <= 16'd0;
      long_q      <= 1'b0;
      rem_q       <= 16'd0;
      crc_q       <= 16'hFFFF;
      gap_q       <= 16'd0;
      pkt_data_q  <= 8'h00;
      pkt_valid_q <= 1'b0;
      pkt_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      di_q        <= di_d;
      wc_q        <= wc_d;
      long_q      <= long_d;
      rem_q       <= rem_d;
      crc_q       <= crc_d;
      gap_q       <= gap_d;
      pkt_data_q  <= pkt_data_d;
      pkt_valid_q <= pkt_valid_d;
      pkt_last_q  <= pkt_last_d;
      err_q       <= err_d;
    end
  end

endmodule
